// File: rtl/esc_telem_tx.sv
// ESC telemetry transmitter: latches one sample on request and sends it as a
// 10-byte frame (9 payload bytes + CRC8) over UART 8N1, LSB first.
module esc_telem_tx #(
    parameter int BAUD_DIV = 87
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic [7:0]  temp_i,
    input  logic [15:0] volt_i,
    input  logic [15:0] curr_i,
    input  logic [15:0] cons_i,
    input  logic [15:0] erpm_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        tx_o
);

    localparam logic [15:0] BD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [7:0]  cur_byte;
    logic [63:0] pay;
    logic [7:0]  crc;
    logic        tick;

    // CRC8 poly 0x07, MSB first, one whole byte per call
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction

    assign tick = (baud_cnt == BD_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            crc      <= 8'h00;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            cur_byte <= '0;
            pay      <= '0;
        end else begin
            done_o <= 1'b0;
            if (busy_o)
                baud_cnt <= tick ? 16'd0 : baud_cnt + 16'd1;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (req_i) begin
                        // B0 goes straight out; B1..B8 wait in pay, MSB byte first
                        pay      <= {volt_i, curr_i, cons_i, erpm_i};
                        cur_byte <= temp_i;
                        crc      <= crc8_byte(8'h00, temp_i);
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        tx_o     <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_o    <= cur_byte[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_o    <= cur_byte[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (byte_idx == 4'd9) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            tx_o   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            // next byte's CRC is folded in as it starts, so B9 is ready in time
                            if (byte_idx == 4'd8) begin
                                cur_byte <= crc;
                            end else begin
                                cur_byte <= pay[63:56];
                                pay      <= {pay[55:0], 8'h00};
                                crc      <= crc8_byte(crc, pay[63:56]);
                            end
                            byte_idx <= byte_idx + 4'd1;
                            tx_o     <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esc_telem_tx.sv
// Scoreboard bench for esc_telem_tx: three instances (BAUD_DIV 4, 2, 87), a UART
// decoding monitor per instance, and a long-division CRC reference model.
module tb_esc_telem_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [7:0]  temp = '0;
    logic [15:0] volt = '0, curr = '0, cons = '0, erpm = '0;
    logic [2:0]  busy_v, done_v, tx_v;

    int checks = 0;
    int failures = 0;

    logic [79:0] exq0[$], exq1[$], exq2[$];

    always #5 clk = ~clk;

    esc_telem_tx #(.BAUD_DIV(4)) u_bd4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req[0]),
        .temp_i(temp), .volt_i(volt), .curr_i(curr), .cons_i(cons), .erpm_i(erpm),
        .busy_o(busy_v[0]), .done_o(done_v[0]), .tx_o(tx_v[0]));

    esc_telem_tx #(.BAUD_DIV(2)) u_bd2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req[1]),
        .temp_i(temp), .volt_i(volt), .curr_i(curr), .cons_i(cons), .erpm_i(erpm),
        .busy_o(busy_v[1]), .done_o(done_v[1]), .tx_o(tx_v[1]));

    esc_telem_tx #(.BAUD_DIV(87)) u_bd87 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req[2]),
        .temp_i(temp), .volt_i(volt), .curr_i(curr), .cons_i(cons), .erpm_i(erpm),
        .busy_o(busy_v[2]), .done_o(done_v[2]), .tx_o(tx_v[2]));

    function automatic int bd_of(input int k);
        case (k)
            0: return 4;
            1: return 2;
            default: return 87;
        endcase
    endfunction

    // Remainder of msg * x^8 divided by x^8 + x^2 + x + 1
    function automatic logic [7:0] model_crc(input logic [71:0] msg);
        logic [79:0] r;
        r = {msg, 8'h00};
        for (int i = 79; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int k, input logic [79:0] v);
        case (k)
            0: exq0.push_back(v);
            1: exq1.push_back(v);
            default: exq2.push_back(v);
        endcase
    endfunction

    function automatic bit pop_exp(input int k, output logic [79:0] v);
        v = '0;
        case (k)
            0: if (exq0.size() > 0) begin v = exq0.pop_front(); return 1'b1; end
            1: if (exq1.size() > 0) begin v = exq1.pop_front(); return 1'b1; end
            default: if (exq2.size() > 0) begin v = exq2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0: return exq0.size();
            1: return exq1.size();
            default: return exq2.size();
        endcase
    endfunction

    // Decode whole frames from the line, checking every cycle of every bit
    task automatic monitor(input int k);
        int          bd;
        logic [99:0] bits;
        logic [79:0] exp, got;
        logic [7:0]  b;
        bit          have_exp, abort, line_ok, frame_ok;
        bd = bd_of(k);
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (done_v[k] !== 1'b0) check($sformatf("k%0d_spurious_done", k), 80'(done_v[k]), 80'd0);
            if (tx_v[k] !== 1'b0) continue;
            have_exp = pop_exp(k, exp);
            if (!have_exp) check($sformatf("k%0d_unexpected_frame", k), 80'd1, 80'd0);
            line_ok = 1'b1;
            abort   = 1'b0;
            bits    = '0;
            for (int c = 0; c < 100 * bd; c++) begin
                if (c > 0) @(negedge clk);
                if (rst) begin abort = 1'b1; break; end
                if (c % bd == 0) bits[c / bd] = tx_v[k];
                else if (tx_v[k] !== bits[c / bd]) line_ok = 1'b0;
                if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) line_ok = 1'b0;
            end
            if (abort) continue;
            @(negedge clk);
            check($sformatf("k%0d_end_of_frame{done,busy,tx}", k),
                  80'({done_v[k], busy_v[k], tx_v[k]}), 80'(3'b101));
            check($sformatf("k%0d_bit_timing_busy", k), 80'(line_ok), 80'd1);
            frame_ok = 1'b1;
            got = '0;
            for (int j = 0; j < 10; j++) begin
                if (bits[10*j] !== 1'b0 || bits[10*j+9] !== 1'b1) frame_ok = 1'b0;
                for (int i = 0; i < 8; i++) b[i] = bits[10*j+1+i];
                got[79-8*j -: 8] = b;
            end
            check($sformatf("k%0d_start_stop_bits", k), 80'(frame_ok), 80'd1);
            if (have_exp)
                for (int j = 0; j < 10; j++)
                    check($sformatf("k%0d_B%0d", k, j), 80'(got[79-8*j -: 8]), 80'(exp[79-8*j -: 8]));
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic wait_idle(input int k);
        int n = 0;
        @(negedge clk);
        while (busy_v[k] && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[k]) check($sformatf("k%0d_idle_timeout", k), 80'd1, 80'd0);
    endtask

    task automatic set_fields(input logic [7:0] t, input logic [15:0] v, input logic [15:0] c,
                              input logic [15:0] s, input logic [15:0] e);
        temp = t; volt = v; curr = c; cons = s; erpm = e;
    endtask

    task automatic randomize_fields();
        set_fields(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // crc_fix < 0 takes B9 from the reference model, otherwise from the given value
    task automatic send(input int k, input int crc_fix);
        logic [71:0] msg;
        logic [7:0]  crc;
        wait_idle(k);
        msg = {temp, volt, curr, cons, erpm};
        crc = (crc_fix < 0) ? model_crc(msg) : 8'(crc_fix);
        push_exp(k, {msg, crc});
        req[k] = 1'b1;
        @(posedge clk);
        #1 req[k] = 1'b0;
    endtask

    task automatic finish_frame(input int k);
        wait_idle(k);
        repeat (3) @(negedge clk);
    endtask

    task automatic held_req(input int k);
        logic [71:0] msg;
        int d = 0, n = 0;
        wait_idle(k);
        randomize_fields();
        msg = {temp, volt, curr, cons, erpm};
        repeat (3) push_exp(k, {msg, model_crc(msg)});
        req[k] = 1'b1;
        while (d < 3 && n < 3 * (100 * bd_of(k) + 10)) begin
            @(negedge clk);
            if (done_v[k]) d++;
            n++;
        end
        req[k] = 1'b0;
        check($sformatf("k%0d_held_done_count", k), 80'(d), 80'd3);
        finish_frame(k);
        check($sformatf("k%0d_held_pending", k), 80'(q_size(k)), 80'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", 80'(tx_v), 80'(3'b111));
        check("reset_busy", 80'(busy_v), 80'd0);
        check("reset_done", 80'(done_v), 80'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_fields(8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        send(0, 8'h00); finish_frame(0);

        set_fields(8'h12, 16'h3456, 16'h789A, 16'hBCDE, 16'h0001);
        send(0, -1); finish_frame(0);

        set_fields(8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
        send(0, 8'h07); finish_frame(0);
        set_fields(8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0002);
        send(0, 8'h0E); finish_frame(0);

        // inputs and req change mid-frame must not disturb it
        randomize_fields();
        send(0, -1);
        repeat (60) @(negedge clk);
        randomize_fields();
        req[0] = 1'b1;
        repeat (5) @(negedge clk);
        req[0] = 1'b0;
        finish_frame(0);
        repeat (20) @(negedge clk);
        check("hold_no_second_frame", 80'(busy_v[0]), 80'd0);

        for (int i = 0; i < 6; i++) begin
            randomize_fields();
            send(0, -1);
            finish_frame(0);
        end

        // reset mid-frame
        randomize_fields();
        send(0, -1);
        repeat (150) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_tx_async", 80'(tx_v[0]), 80'd1);
        check("midreset_busy", 80'(busy_v[0]), 80'd0);
        check("midreset_done", 80'(done_v[0]), 80'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("post_reset_idle{busy,tx}", 80'({busy_v[0], tx_v[0]}), 80'(2'b01));
        check("post_reset_abandoned", 80'(q_size(0)), 80'd0);

        held_req(0);
        held_req(1);
        held_req(2);

        check("final_pending", 80'(q_size(0) + q_size(1) + q_size(2)), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
